// File: rtl/step_counter_pkg.sv
// Shared types and constants for the step_counter block.
package step_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } counter_mode_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/step_counter_prescaler_tick.sv
// Enable prescaler: emits a tick every prescale+1 enabled cycles.
module prescaler_tick #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] pc_q, pc_d;

    // >= rather than == so lowering prescale below pc fires on the next enabled cycle
    assign tick = enable && (pc_q >= prescale);

    always_comb begin
        pc_d = pc_q;
        if (clear || tick) begin
            pc_d = '0;
        end else if (enable) begin
            pc_d = pc_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/step_counter.sv
// Up/down modulo counter with load, wrap/saturate/one-shot modes and enable prescaler.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      up_down,
    input  logic [1:0]                mode,
    input  logic [WIDTH-1:0]          max_value,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]          compare,
    output logic [WIDTH-1:0]          q,
    output logic                      tc,
    output logic                      done,
    output logic                      cmp_match
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             step;
    logic             at_max;
    logic             at_zero;
    counter_mode_t    mode_e;

    prescaler_tick #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .clear   (load),
        .prescale(prescale),
        .tick    (step)
    );

    assign mode_e  = counter_mode_t'(mode);
    assign at_max  = (q_q >= max_value);
    assign at_zero = (q_q == '0);

    always_comb begin
        q_d    = q_q;
        tc_d   = 1'b0;
        done_d = done_q;
        if (load) begin
            q_d    = load_value;
            done_d = 1'b0;
        end else if (step && !done_q) begin
            if (up_down == DIR_UP) begin
                if (!at_max) begin
                    q_d = q_q + WIDTH'(1);
                    if (mode_e == MODE_ONESHOT && q_d == max_value) begin
                        done_d = 1'b1;
                        tc_d   = 1'b1;
                    end
                end else begin
                    tc_d = 1'b1;
                    unique case (mode_e)
                        MODE_SAT:     q_d = max_value;
                        // Already at/above the bound: finish immediately, clamped to the bound
                        MODE_ONESHOT: begin
                            q_d    = max_value;
                            done_d = 1'b1;
                        end
                        default:      q_d = '0;
                    endcase
                end
            end else begin
                if (!at_zero) begin
                    q_d = q_q - WIDTH'(1);
                    if (mode_e == MODE_ONESHOT && q_d == '0) begin
                        done_d = 1'b1;
                        tc_d   = 1'b1;
                    end
                end else begin
                    tc_d = 1'b1;
                    unique case (mode_e)
                        MODE_SAT:     q_d = '0;
                        MODE_ONESHOT: done_d = 1'b1;
                        default:      q_d = max_value;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign q         = q_q;
    assign tc        = tc_q;
    assign done      = done_q;
    assign cmp_match = (q_q == compare);

endmodule

// File: tb/tb_step_counter.sv
// Directed scoreboard bench for step_counter (WIDTH=8, PRESCALE_WIDTH=8).
module tb_step_counter;

    localparam int W  = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          load;
    logic [W-1:0]  load_value;
    logic          up_down;
    logic [1:0]    mode;
    logic [W-1:0]  max_value;
    logic [PW-1:0] prescale;
    logic [W-1:0]  compare;
    logic [W-1:0]  q;
    logic          tc;
    logic          done;
    logic          cmp_match;

    step_counter #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .load_value(load_value),
        .up_down   (up_down),
        .mode      (mode),
        .max_value (max_value),
        .prescale  (prescale),
        .compare   (compare),
        .q         (q),
        .tc        (tc),
        .done      (done),
        .cmp_match (cmp_match)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [W-1:0] q;
        logic         tc;
        logic         done;
        logic         cm;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each expectation is tagged with the edge after which it holds.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || q !== e.q || tc !== e.tc || done !== e.done || cmp_match !== e.cm) begin
                failures++;
                $display("FAIL %s cyc=%0d: got q=%0d tc=%b done=%b cmp=%b, want q=%0d tc=%b done=%b cmp=%b",
                         e.name, cyc, q, tc, done, cmp_match, e.q, e.tc, e.done, e.cm);
            end
        end
    end

    // Push the expected outputs after the coming edge, then advance one cycle.
    task automatic step(input string name, input int eq, input bit etc, input bit edone);
        exp_t e;
        e.cyc  = cyc + 1;
        e.q    = W'(eq);
        e.tc   = etc;
        e.done = edone;
        e.cm   = (W'(eq) == compare);
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string name, input int v);
        load       = 1'b1;
        load_value = W'(v);
        step(name, v, 1'b0, 1'b0);
        load       = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        load       = 1'b0;
        load_value = '0;
        up_down    = 1'b1;
        mode       = 2'b00;
        max_value  = 8'd5;
        prescale   = '0;
        compare    = 8'd4;

        step("reset", 0, 0, 0);
        step("reset_hold", 0, 0, 0);
        reset = 1'b0;

        // Wrap up-count 0..5 then roll to 0 with tc; cmp_match tracks q==4
        step("wrap_up1", 1, 0, 0);
        step("wrap_up2", 2, 0, 0);
        step("wrap_up3", 3, 0, 0);
        step("wrap_up4", 4, 0, 0);
        step("wrap_up5", 5, 0, 0);
        step("wrap_roll", 0, 1, 0);
        step("wrap_after", 1, 0, 0);

        // Saturate down from 2
        mode    = 2'b01;
        up_down = 1'b0;
        do_load("sat_load", 2);
        step("sat_dn1", 1, 0, 0);
        step("sat_dn0", 0, 0, 0);
        step("sat_hold1", 0, 1, 0);
        step("sat_hold2", 0, 1, 0);

        // One-shot up to 3, then reload clears done
        mode      = 2'b10;
        up_down   = 1'b1;
        max_value = 8'd3;
        do_load("os_load0", 0);
        step("os_1", 1, 0, 0);
        step("os_2", 2, 0, 0);
        step("os_done", 3, 1, 1);
        step("os_hold1", 3, 0, 1);
        step("os_hold2", 3, 0, 1);
        do_load("os_reload", 1);
        step("os_resume", 2, 0, 0);

        // Prescale 3: step every 4th enabled cycle, frozen while disabled
        mode      = 2'b00;
        max_value = 8'd5;
        prescale  = 8'd3;
        do_load("ps_load", 0);
        step("ps_w1", 0, 0, 0);
        step("ps_w2", 0, 0, 0);
        step("ps_w3", 0, 0, 0);
        step("ps_step", 1, 0, 0);
        step("ps_w4", 1, 0, 0);
        step("ps_w5", 1, 0, 0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) step("ps_frozen", 1, 0, 0);
        enable = 1'b1;
        step("ps_resume_w", 1, 0, 0);
        step("ps_resume_step", 2, 0, 0);

        // prescale 9 -> 2 with pc=5 steps on next enabled cycle
        prescale = 8'd9;
        do_load("ps9_load", 0);
        for (int i = 0; i < 5; i++) step("ps9_wait", 0, 0, 0);
        prescale = 8'd2;
        step("ps_lowered", 1, 0, 0);

        // Load collides with a due step: load wins, pc cleared
        prescale  = 8'd1;
        max_value = 8'd10;
        do_load("ld_pc0", 0);
        step("ld_w", 0, 0, 0);
        do_load("ld_vs_step", 7);
        step("ld_pc_clear", 7, 0, 0);
        step("ld_next", 8, 0, 0);

        // Reset while q=4, done=1
        prescale  = '0;
        mode      = 2'b10;
        max_value = 8'd4;
        do_load("rst_load", 3);
        step("rst_os_done", 4, 1, 1);
        reset = 1'b1;
        step("rst_mid", 0, 0, 0);
        reset  = 1'b0;
        enable = 1'b0;
        step("rst_idle", 0, 0, 0);

        // Out-of-range load wraps to 0 on next up step
        enable    = 1'b1;
        mode      = 2'b00;
        max_value = 8'd10;
        do_load("oor_load", 200);
        step("oor_wrap", 0, 1, 0);

        // Down wrap from 0 goes to max_value; reserved mode behaves as wrap
        up_down = 1'b0;
        mode    = 2'b11;
        step("dn_wrap", 10, 1, 0);
        step("dn_after", 9, 0, 0);

        begin
            int n = 0;
            while (sb.size() > 0 && n < 10) begin
                @(posedge clk);
                n++;
            end
            if (sb.size() > 0) begin
                failures++;
                $display("FAIL drain: got %0d pending, want 0", sb.size());
            end
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
